// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 8-digit 7-segment scan driver.
// Each digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles to kill ghosting,
// then the digit is shown. Loaded data waits in a shadow register set and is
// committed only at the frame boundary, so a frame never mixes two values.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV    = 5000,
   parameter int BLANK_CYC   = 50,
   parameter bit COM_ACT_LOW = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [31:0] i_value,
   input  logic [7:0]  i_dot,
   input  logic [7:0]  i_en_mask,
   input  logic        i_lz_sup,
   output logic [7:0]  o_seg_d,
   output logic [7:0]  o_seg_com,
   output logic        o_pending,
   output logic        o_frame_done
);

   localparam int               CNT_W      = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [0:0]       ST_BLANK   = 1'b0;
   localparam logic [0:0]       ST_SHOW    = 1'b1;
   // With no blanking period a slot opens directly in SHOW.
   localparam logic [0:0]       ST_FIRST   = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
   localparam logic [7:0]       COM_OFF    = COM_ACT_LOW ? 8'hFF : 8'h00;

   // Hex nibble to {g,f,e,d,c,b,a} segment pattern.
   function automatic logic [6:0] enc(input logic [3:0] h);
      case (h)
         4'h0: enc = 7'h3f;
         4'h1: enc = 7'h06;
         4'h2: enc = 7'h5b;
         4'h3: enc = 7'h4f;
         4'h4: enc = 7'h66;
         4'h5: enc = 7'h6d;
         4'h6: enc = 7'h7d;
         4'h7: enc = 7'h27;
         4'h8: enc = 7'h7f;
         4'h9: enc = 7'h6f;
         4'hA: enc = 7'h5f;
         4'hB: enc = 7'h7c;
         4'hC: enc = 7'h58;
         4'hD: enc = 7'h5e;
         4'hE: enc = 7'h7b;
         default: enc = 7'h71;
      endcase
   endfunction

   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [0:0]       state;
   logic             frame_done;
   logic             pending;
   logic             slot_end;

   logic [31:0] act_value;
   logic [7:0]  act_dot;
   logic [7:0]  act_en;
   logic        act_lz;
   logic [31:0] pend_value;
   logic [7:0]  pend_dot;
   logic [7:0]  pend_en;
   logic        pend_lz;

   logic [7:0]  upper_zero;
   logic [3:0]  nib;
   logic        digit_on;
   logic [7:0]  seg_d;
   logic [7:0]  seg_com;

   assign slot_end = (cnt == LAST_CNT);

   // upper_zero[k]: digits k..7 of the active value are all zero.
   always_comb begin
      upper_zero = 8'h00;
      for (int k = 0; k < 8; k++)
         upper_zero[k] = ((act_value >> (4 * k)) == 32'h0);
   end

   // Decide whether the current digit lights: enabled and not a suppressed leading zero.
   always_comb begin
      nib      = act_value[{idx, 2'b00} +: 4];
      digit_on = act_en[idx] && !(act_lz && (idx != 3'd0) && upper_zero[idx]);
   end

   // Slot prescaler, digit index and BLANK/SHOW sequencing; flags the 7->0 wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt        <= '0;
         idx        <= 3'd0;
         state      <= ST_BLANK;
         frame_done <= 1'b0;
      end else begin
         frame_done <= slot_end && (idx == 3'd7);
         if (slot_end) begin
            cnt   <= '0;
            idx   <= idx + 3'd1;
            state <= ST_FIRST;
         end else begin
            cnt <= cnt + CNT_ONE;
            if ((state == ST_BLANK) && (cnt == BLANK_LAST))
               state <= ST_SHOW;
         end
      end
   end

   // Load handshake: shadow capture, commit to active on the frame_done cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending    <= 1'b0;
         act_value  <= 32'h0;
         act_dot    <= 8'h00;
         act_en     <= 8'h00;
         act_lz     <= 1'b0;
         pend_value <= 32'h0;
         pend_dot   <= 8'h00;
         pend_en    <= 8'h00;
         pend_lz    <= 1'b0;
      end else begin
         if (frame_done && pending) begin
            act_value <= pend_value;
            act_dot   <= pend_dot;
            act_en    <= pend_en;
            act_lz    <= pend_lz;
         end
         if (i_load) begin
            pend_value <= i_value;
            pend_dot   <= i_dot;
            pend_en    <= i_en_mask;
            pend_lz    <= i_lz_sup;
            pending    <= 1'b1;
         end else if (frame_done) begin
            pending <= 1'b0;
         end
      end
   end

   // Registered pin drivers: dark in BLANK or for a dark digit, else segment pattern + common.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         seg_d   <= 8'h00;
         seg_com <= COM_OFF;
      end else if ((state == ST_SHOW) && digit_on) begin
         seg_d   <= {act_dot[idx], enc(nib)};
         seg_com <= COM_ACT_LOW ? ~(8'h01 << idx) : (8'h01 << idx);
      end else begin
         seg_d   <= 8'h00;
         seg_com <= COM_OFF;
      end
   end

   assign o_seg_d      = seg_d;
   assign o_seg_com    = seg_com;
   assign o_pending    = pending;
   assign o_frame_done = frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2, active-high commons.
// The reference model tracks time since reset release and derives the slot,
// phase and displayed data from plain arithmetic on that cycle count.
module tb_seg7_scan_ctrl;

   localparam int SD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 8 * SD;

   logic        clk;
   logic        rst;
   logic        load;
   logic [31:0] value;
   logic [7:0]  dot;
   logic [7:0]  en_mask;
   logic        lz_sup;
   logic [7:0]  seg_d;
   logic [7:0]  seg_com;
   logic        pending;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          n;
   logic [31:0] a_val, p_val;
   logic [7:0]  a_dot, p_dot, a_en, p_en;
   logic        a_lz, p_lz, p_flag;
   logic [7:0]  exp_seg, exp_com;
   logic        exp_fd, exp_pend;
   logic [6:0]  enc_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
                                 7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71};

   seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .COM_ACT_LOW(1'b0)) dut (
      .i_clk(clk), .i_rst(rst), .i_load(load), .i_value(value), .i_dot(dot),
      .i_en_mask(en_mask), .i_lz_sup(lz_sup), .o_seg_d(seg_d), .o_seg_com(seg_com),
      .o_pending(pending), .o_frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit digit_lit(int slot);
      if (!a_en[slot]) return 1'b0;
      if (a_lz && slot != 0 && (a_val >> (4 * slot)) == 32'h0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int next_boundary();
      return (n / FRAME + 1) * FRAME;
   endfunction

   task automatic model_reset();
      n = 0;
      a_val = 0; a_dot = 0; a_en = 0; a_lz = 0;
      p_val = 0; p_dot = 0; p_en = 0; p_lz = 0; p_flag = 0;
      exp_seg = 0; exp_com = 0; exp_fd = 0; exp_pend = 0;
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic tick(input bit ld, input logic [31:0] v, input logic [7:0] d,
                       input logic [7:0] e, input bit lz);
      int phase, slot;
      bit fd;
      load = ld; value = v; dot = d; en_mask = e; lz_sup = lz;
      @(posedge clk);
      phase = n % SD;
      slot  = (n / SD) % 8;
      if (phase >= BC && digit_lit(slot)) begin
         exp_com = 8'h01 << slot;
         exp_seg = {a_dot[slot], enc_tab[a_val[4 * slot +: 4]]};
      end else begin
         exp_com = 8'h00;
         exp_seg = 8'h00;
      end
      fd = (n > 0) && (n % FRAME == 0);
      if (fd && p_flag) begin
         a_val = p_val; a_dot = p_dot; a_en = p_en; a_lz = p_lz;
      end
      if (ld) begin
         p_val = v; p_dot = d; p_en = e; p_lz = lz; p_flag = 1'b1;
      end else if (fd) begin
         p_flag = 1'b0;
      end
      n++;
      exp_fd   = (n % FRAME == 0);
      exp_pend = p_flag;
      #1;
      load = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (seg_d !== 8'h00) begin errors++; $display("FAIL reset_seg got=%h want=00", seg_d); end
      checks++;
      if (seg_com !== 8'h00) begin errors++; $display("FAIL reset_com got=%h want=00", seg_com); end
      checks++;
      if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b want=0", pending); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
   endtask

   task automatic test_idle();
      while (n < 130) begin
         tick(1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL idle_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL idle_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
      end
   endtask

   task automatic test_load_pending();
      int b, s;
      b = next_boundary();
      s = n;
      while (n < b + 66) begin
         tick(n == s, 32'h8765_4321, 8'h01, 8'hFF, 1'b0);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL load_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL load_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
         if (n == s + 1) begin
            checks++;
            if (pending !== 1'b1) begin errors++; $display("FAIL load_pending_set got=%b want=1", pending); end
         end
         if (n == b + 3) begin
            checks++;
            if (seg_com !== 8'h01 || seg_d !== 8'h86) begin
               errors++; $display("FAIL load_digit0 got com=%h seg=%h want com=01 seg=86", seg_com, seg_d);
            end
         end
         if (n == b + 59) begin
            checks++;
            if (seg_com !== 8'h80 || seg_d !== 8'h7f) begin
               errors++; $display("FAIL load_digit7 got com=%h seg=%h want com=80 seg=7f", seg_com, seg_d);
            end
         end
      end
   endtask

   task automatic test_lz_sup();
      int b, s;
      b = next_boundary();
      s = n;
      while (n < b + 66) begin
         tick(n == s, 32'h0000_0A05, 8'h00, 8'hFF, 1'b1);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL lz_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL lz_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
         if (n == b + 3) begin
            checks++;
            if (seg_com !== 8'h01 || seg_d !== 8'h6d) begin
               errors++; $display("FAIL lz_digit0 got com=%h seg=%h want com=01 seg=6d", seg_com, seg_d);
            end
         end
         if (n == b + 11) begin
            checks++;
            if (seg_com !== 8'h02 || seg_d !== 8'h3f) begin
               errors++; $display("FAIL lz_digit1 got com=%h seg=%h want com=02 seg=3f", seg_com, seg_d);
            end
         end
         if (n == b + 19) begin
            checks++;
            if (seg_com !== 8'h04 || seg_d !== 8'h5f) begin
               errors++; $display("FAIL lz_digit2 got com=%h seg=%h want com=04 seg=5f", seg_com, seg_d);
            end
         end
         if (n == b + 27) begin
            checks++;
            if (seg_com !== 8'h00 || seg_d !== 8'h00) begin
               errors++; $display("FAIL lz_digit3 got com=%h seg=%h want com=00 seg=00", seg_com, seg_d);
            end
         end
      end
   endtask

   task automatic test_en_mask();
      int b, s;
      b = next_boundary();
      s = n;
      while (n < b + 130) begin
         tick(n == s, 32'h1111_1111, 8'h00, 8'hF0, 1'b0);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL en_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL en_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
         if (n == b + 3) begin
            checks++;
            if (seg_com !== 8'h00) begin errors++; $display("FAIL en_slot0 got com=%h want com=00", seg_com); end
         end
         if (n == b + 35) begin
            checks++;
            if (seg_com !== 8'h10 || seg_d !== 8'h06) begin
               errors++; $display("FAIL en_slot4 got com=%h seg=%h want com=10 seg=06", seg_com, seg_d);
            end
         end
         if (n == b + 128) begin
            checks++;
            if (frame_done !== 1'b1) begin errors++; $display("FAIL en_frame_len got fd=%b want=1", frame_done); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int s, b1, b2, b3;
      b1 = next_boundary();
      b2 = b1 + FRAME;
      b3 = b2 + FRAME;
      s  = n;
      while (n < b3 + 4) begin
         if (n == s)           tick(1'b1, 32'h2222_2222, 8'h00, 8'hFF, 1'b0);
         else if (n == s + 5)  tick(1'b1, 32'h3333_3333, 8'h00, 8'hFF, 1'b0);
         else if (n == b2)     tick(1'b1, 32'h4444_4444, 8'h00, 8'hFF, 1'b0);
         else                  tick(1'b0, 32'h0, 8'h00, 8'h00, 1'b0);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL b2b_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL b2b_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
         if (n == b1 + 3) begin
            checks++;
            if (seg_d !== 8'h4f) begin errors++; $display("FAIL b2b_last_wins got seg=%h want seg=4f", seg_d); end
         end
         if (n == b2 + 1) begin
            checks++;
            if (pending !== 1'b1) begin errors++; $display("FAIL b2b_boundary_pending got=%b want=1", pending); end
         end
         if (n == b2 + 3) begin
            checks++;
            if (seg_d !== 8'h4f) begin errors++; $display("FAIL b2b_boundary_old got seg=%h want seg=4f", seg_d); end
         end
         if (n == b3 + 3) begin
            checks++;
            if (seg_d !== 8'h66) begin errors++; $display("FAIL b2b_boundary_new got seg=%h want seg=66", seg_d); end
         end
      end
   endtask

   task automatic test_random();
      int stop;
      bit ld;
      stop = n + 6 * FRAME;
      while (n < stop) begin
         ld = ($urandom_range(0, 19) == 0) || ((n % FRAME == 0) && ($urandom_range(0, 1) == 1));
         tick(ld, $urandom(), 8'($urandom()), 8'($urandom()), 1'($urandom()));
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL rand_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL rand_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
      end
   endtask

   task automatic test_reset_mid();
      int b, s;
      b = next_boundary();
      s = n;
      while (n < b + 28) begin
         if (n == s)           tick(1'b1, 32'h7654_3210, 8'h00, 8'hFF, 1'b0);
         else if (n == b + 10) tick(1'b1, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 1'b0);
         else                  tick(1'b0, 32'h0, 8'h00, 8'h00, 1'b0);
      end
      checks++;
      if (seg_com !== 8'h08 || seg_d !== 8'h4f || pending !== 1'b1) begin
         errors++; $display("FAIL rstmid_before got com=%h seg=%h pend=%b want com=08 seg=4f pend=1", seg_com, seg_d, pending);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (seg_com !== 8'h00 || seg_d !== 8'h00) begin
         errors++; $display("FAIL rstmid_async got com=%h seg=%h want com=00 seg=00", seg_com, seg_d);
      end
      checks++;
      if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending got=%b want=0", pending); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      while (n < 140) begin
         tick(n == 0, 32'h7654_3210, 8'h00, 8'hFF, 1'b0);
         checks++;
         if (seg_d !== exp_seg || seg_com !== exp_com) begin
            errors++; $display("FAIL rstmid_out n=%0d got seg=%h com=%h want seg=%h com=%h", n, seg_d, seg_com, exp_seg, exp_com);
         end
         checks++;
         if (frame_done !== exp_fd || pending !== exp_pend) begin
            errors++; $display("FAIL rstmid_ctl n=%0d got fd=%b pend=%b want fd=%b pend=%b", n, frame_done, pending, exp_fd, exp_pend);
         end
         if (n == 67) begin
            checks++;
            if (seg_com !== 8'h01 || seg_d !== 8'h3f) begin
               errors++; $display("FAIL rstmid_restart got com=%h seg=%h want com=01 seg=3f", seg_com, seg_d);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value = 32'h0; dot = 8'h0; en_mask = 8'h0; lz_sup = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_idle();
      test_load_pending();
      test_lz_sup();
      test_en_mask();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
